// File: rtl/iob_im_blit_pkg.sv
// Shared definitions for the image blitter.
//   BLIT_LAT     : cycles from pixel presentation to rgb
//   SCALE_W      : width of the log2 scale field
//   DEF_*        : default frame colour and transparent key (12-bit rgb)
//   blit_cfg_t   : one image placement {isel, x, y, scale}; fields are sized
//                  for the widest supported build and zero-extended on entry.
package iob_im_blit_pkg;

  localparam int BLIT_LAT   = 3;
  localparam int SCALE_W    = 2;
  localparam int CFG_ISEL_W = 8;
  localparam int CFG_PIX_W  = 16;

  localparam logic [11:0] DEF_FRAME_COLOR = 12'hFFF;
  localparam logic [11:0] DEF_TRANSP_KEY  = 12'hF0F;

  typedef struct packed {
    logic [CFG_ISEL_W-1:0] isel;
    logic [CFG_PIX_W-1:0]  x;
    logic [CFG_PIX_W-1:0]  y;
    logic [SCALE_W-1:0]    scale;
  } blit_cfg_t;

endpackage

// File: rtl/imemory_blit_cfg.sv
// Shadow/active configuration registers with valid/ready intake.
//   i_valid/o_ready          : config handshake (ready while nothing pending)
//   i_isel/i_x/i_y/i_scale   : requested placement
//   i_frame_start            : promotes a pending shadow config to active
//   o_act                    : active placement
//   o_base                   : ROM base of the active image (isel*IMG_W*IMG_H)
module imemory_blit_cfg
  import iob_im_blit_pkg::*;
#(
  parameter int ISEL_W = 2,
  parameter int PIX_W  = 10,
  parameter int IMG_W  = 40,
  parameter int IMG_H  = 40,
  parameter int ADDR_W = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [ISEL_W-1:0]  i_isel,
  input  logic [PIX_W-1:0]   i_x,
  input  logic [PIX_W-1:0]   i_y,
  input  logic [SCALE_W-1:0] i_scale,
  input  logic               i_frame_start,
  output blit_cfg_t          o_act,
  output logic [ADDR_W-1:0]  o_base
);

  localparam int IMG_SZ = IMG_W * IMG_H;

  blit_cfg_t         r_shadow, r_act;
  logic              r_pending;
  logic [ADDR_W-1:0] r_base;
  logic              w_accept, w_load;

  // accept and load are mutually exclusive: accept needs !pending, load needs
  // pending. A request landing on a frame_start therefore waits a frame.
  assign w_accept = i_valid & ~r_pending;
  assign w_load   = i_frame_start & r_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow  <= '0;
      r_act     <= '0;
      r_pending <= 1'b0;
      r_base    <= '0;
    end else begin
      if (w_accept) begin
        r_shadow.isel  <= CFG_ISEL_W'(i_isel);
        r_shadow.x     <= CFG_PIX_W'(i_x);
        r_shadow.y     <= CFG_PIX_W'(i_y);
        r_shadow.scale <= i_scale;
        r_pending      <= 1'b1;
      end else if (w_load) begin
        r_pending <= 1'b0;
      end
      if (w_load) begin
        r_act  <= r_shadow;
        // out-of-range selectors truncate here; the top masks them via isel
        r_base <= ADDR_W'(32'(r_shadow.isel) * IMG_SZ);
      end
    end
  end

  assign o_ready = ~r_pending;
  assign o_act   = r_act;
  assign o_base  = r_base;

endmodule

// File: rtl/iob_rom_sp.sv
// Single-port synchronous image ROM.
//   clk    : clock
//   i_en   : read enable; o_data holds its value while low
//   i_addr : word address
//   o_data : registered read data, one cycle after i_en
// Contents are a fixed test card: word a = (7a+3) mod 2^DATA_W, except word
// 410 holds the transparent key 12'hF0F and word 411 holds 12'h123.
module iob_rom_sp #(
  parameter int DATA_W  = 12,
  parameter int ADDR_W  = 13,
  parameter     HEXFILE = "none"
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] o_data
);

  function automatic logic [DATA_W-1:0] img_word(input logic [ADDR_W-1:0] a);
    if (a == ADDR_W'(410)) return DATA_W'(12'hF0F);
    if (a == ADDR_W'(411)) return DATA_W'(12'h123);
    return DATA_W'(32'(a) * 32'd7 + 32'd3);
  endfunction

  // Only the built-in test card is carried; a file-backed image set would
  // silently diverge from it, so refuse to elaborate instead.
  if (HEXFILE != "none") begin : g_nofile
    $error("iob_rom_sp: only the built-in image set is available");
  end

  always_ff @(posedge clk) begin
    if (i_en) o_data <= img_word(i_addr);
  end

endmodule

// File: rtl/imemory_blit.sv
// Scaled, colour-keyed image blitter for the VGA pixel path.
//   clk, rst                 : clock, synchronous active-high reset
//   cfg_*                    : placement request, valid/ready, applied at frame_start
//   frame_start              : pulse before the first pixel of a frame
//   pixel_valid/x/y          : current raster position
//   rgb/rgb_valid/in_image   : colour for the pixel presented 3 cycles earlier
module imemory_blit
  import iob_im_blit_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int PIX_W  = 10,
  parameter int IMG_W  = 40,
  parameter int IMG_H  = 40,
  parameter int NIMG   = 4,
  parameter int ISEL_W = 2,
  parameter int ADDR_W = 13,
  parameter logic [DATA_W-1:0] FRAME_COLOR = DATA_W'(DEF_FRAME_COLOR),
  parameter logic [DATA_W-1:0] TRANSP_KEY  = DATA_W'(DEF_TRANSP_KEY),
  parameter     HEXFILE = "none"
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [ISEL_W-1:0]  cfg_isel,
  input  logic [PIX_W-1:0]   cfg_x,
  input  logic [PIX_W-1:0]   cfg_y,
  input  logic [SCALE_W-1:0] cfg_scale,
  input  logic               frame_start,
  input  logic               pixel_valid,
  input  logic [PIX_W-1:0]   pixel_x,
  input  logic [PIX_W-1:0]   pixel_y,
  output logic [DATA_W-1:0]  rgb,
  output logic               rgb_valid,
  output logic               in_image
);

  // geometry is evaluated 4 bits wider than coordinates so x_end never wraps
  localparam int GW   = CFG_PIX_W + 4;
  localparam int IX_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int IY_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  blit_cfg_t         w_act;
  logic [ADDR_W-1:0] w_base;

  imemory_blit_cfg #(
    .ISEL_W(ISEL_W), .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)
  ) u_cfg (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (cfg_valid),
    .o_ready      (cfg_ready),
    .i_isel       (cfg_isel),
    .i_x          (cfg_x),
    .i_y          (cfg_y),
    .i_scale      (cfg_scale),
    .i_frame_start(frame_start),
    .o_act        (w_act),
    .o_base       (w_base)
  );

  // ---- S0 combinational: hit test and image-local coordinates ----
  logic [GW-1:0] w_px, w_py, w_x, w_y, w_xend, w_yend, w_dx, w_dy;
  logic          w_en, w_hit;
  logic [IX_W-1:0] w_idx;
  logic [IY_W-1:0] w_idy;

  assign w_px   = GW'(pixel_x);
  assign w_py   = GW'(pixel_y);
  assign w_x    = GW'(w_act.x);
  assign w_y    = GW'(w_act.y);
  assign w_xend = w_x + (GW'(IMG_W) << w_act.scale) - GW'(1);
  assign w_yend = w_y + (GW'(IMG_H) << w_act.scale) - GW'(1);
  assign w_en   = 32'(w_act.isel) < NIMG;
  assign w_hit  = pixel_valid & w_en &
                  (w_px >= w_x) & (w_px <= w_xend) &
                  (w_py >= w_y) & (w_py <= w_yend);
  assign w_dx   = w_px - w_x;
  assign w_dy   = w_py - w_y;
  assign w_idx  = IX_W'(w_dx >> w_act.scale);
  assign w_idy  = IY_W'(w_dy >> w_act.scale);

  // ---- pipeline registers ----
  logic [BLIT_LAT-1:0] r_vld_pipe;
  logic                r0_hit, r1_hit;
  logic [IX_W-1:0]     r0_idx;
  logic [IY_W-1:0]     r0_idy;
  logic [ADDR_W-1:0]   r0_base;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_rom;
  logic                w_opaque;

  // base travels with the pixel so in-flight pixels survive a config swap
  assign w_addr = r0_base + ADDR_W'(32'(r0_idy) * IMG_W) + ADDR_W'(r0_idx);

  // the ROM's read register is the S1 address/data stage
  iob_rom_sp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .HEXFILE(HEXFILE)) u_rom (
    .clk   (clk),
    .i_en  (r0_hit),
    .i_addr(w_addr),
    .o_data(w_rom)
  );

  assign w_opaque = r1_hit & (w_rom != TRANSP_KEY);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r0_hit     <= 1'b0;
      r0_idx     <= '0;
      r0_idy     <= '0;
      r0_base    <= '0;
      r1_hit     <= 1'b0;
      rgb        <= '0;
      in_image   <= 1'b0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[BLIT_LAT-2:0], pixel_valid};
      r0_hit     <= w_hit;
      r0_idx     <= w_idx;
      r0_idy     <= w_idy;
      r0_base    <= w_base;
      r1_hit     <= r0_hit;
      rgb        <= w_opaque ? w_rom : FRAME_COLOR;
      in_image   <= w_opaque;
    end
  end

  assign rgb_valid = r_vld_pipe[BLIT_LAT-1];

endmodule

// File: tb/tb_imemory_blit.sv
module tb_imemory_blit;

  logic        clk = 1'b0;
  logic        rst, cfg_valid, cfg_ready, frame_start, pixel_valid;
  logic [2:0]  cfg_isel;
  logic [9:0]  cfg_x, cfg_y, pixel_x, pixel_y;
  logic [1:0]  cfg_scale;
  logic [11:0] rgb;
  logic        rgb_valid, in_image;

  imemory_blit #(.ISEL_W(3)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_isel(cfg_isel),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_scale(cfg_scale),
    .frame_start(frame_start), .pixel_valid(pixel_valid),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .rgb(rgb), .rgb_valid(rgb_valid), .in_image(in_image)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct { logic [11:0] rgb; logic inimg; int cyc; } exp_t;
  typedef struct { int isel; int x; int y; int s; } tcfg_t;

  exp_t  q[$];
  exp_t  mon_e;
  tcfg_t m_act, m_sh;
  bit    m_pend;

  // Test-card contents the image ROM is expected to hold
  function automatic logic [11:0] rom_model(input int a);
    logic [11:0] v;
    case (a)
      410:     v = 12'hF0F;
      411:     v = 12'h123;
      default: v = 12'((a * 7 + 3) % 4096);
    endcase
    return v;
  endfunction

  function automatic exp_t model(input int px, input int py);
    exp_t e;
    int w, h, a;
    logic [11:0] d;
    e.rgb = 12'hFFF; e.inimg = 1'b0; e.cyc = cyc;
    w = 40 * (1 << m_act.s);
    h = 40 * (1 << m_act.s);
    if (m_act.isel < 4 && px >= m_act.x && px < m_act.x + w &&
        py >= m_act.y && py < m_act.y + h) begin
      a = m_act.isel * 1600 + ((py - m_act.y) / (1 << m_act.s)) * 40
          + (px - m_act.x) / (1 << m_act.s);
      d = rom_model(a);
      if (d != 12'hF0F) begin e.rgb = d; e.inimg = 1'b1; end
    end
    return e;
  endfunction

  // one clock: check handshake, push expectation, advance model, cross the edge
  task automatic tick();
    bit ld, acc;
    if (!rst) chk("cfg_ready", {31'b0, cfg_ready}, {31'b0, !m_pend});
    if (!rst && pixel_valid) q.push_back(model(int'(pixel_x), int'(pixel_y)));
    if (rst) begin
      m_act = '{0, 0, 0, 0}; m_sh = '{0, 0, 0, 0}; m_pend = 0;
    end else begin
      ld  = frame_start && m_pend;
      acc = cfg_valid && !m_pend;
      if (ld) m_act = m_sh;
      if (acc) begin
        m_sh = '{int'(cfg_isel), int'(cfg_x), int'(cfg_y), int'(cfg_scale)};
        m_pend = 1;
      end else if (ld) m_pend = 0;
    end
    @(posedge clk); #1;
    if (rst) q.delete();
  endtask

  task automatic px(input int x, input int y);
    pixel_valid = 1; pixel_x = 10'(x); pixel_y = 10'(y);
    tick();
    pixel_valid = 0;
  endtask

  task automatic fs();
    frame_start = 1; tick(); frame_start = 0;
  endtask

  task automatic set_cfg(input int isel, input int x, input int y, input int s);
    cfg_isel = 3'(isel); cfg_x = 10'(x); cfg_y = 10'(y); cfg_scale = 2'(s);
  endtask

  task automatic cfg(input int isel, input int x, input int y, input int s);
    set_cfg(isel, x, y, s); cfg_valid = 1; tick(); cfg_valid = 0;
  endtask

  always @(negedge clk) begin
    if (rgb_valid === 1'b1) begin
      if (q.size() == 0) chk("spurious_vld", {31'b0, rgb_valid}, 32'd0);
      else begin
        mon_e = q.pop_front();
        chk("rgb", {20'b0, rgb}, {20'b0, mon_e.rgb});
        chk("in_image", {31'b0, in_image}, {31'b0, mon_e.inimg});
        chk("latency", cyc - mon_e.cyc, 32'd3);
      end
    end
  end

  initial begin
    rst = 1; cfg_valid = 0; frame_start = 0; pixel_valid = 0;
    pixel_x = '0; pixel_y = '0; set_cfg(0, 0, 0, 0);
    tick(); tick();
    rst = 0;
    chk("rst_ready", {31'b0, cfg_ready}, 32'd1);
    chk("rst_rgb", {20'b0, rgb}, 32'd0);
    chk("rst_vld", {31'b0, rgb_valid}, 32'd0);
    chk("rst_inimg", {31'b0, in_image}, 32'd0);

    // default config, including the transparent word and its neighbour
    fs(); px(0, 0); px(10, 10); px(11, 10); px(39, 39); px(40, 0);

    // request mid-frame: old placement until frame_start
    cfg(1, 20, 20, 0);
    px(25, 22);
    fs();
    px(25, 22); px(19, 22); px(59, 59); px(60, 59);

    // 2x edges
    cfg(0, 20, 20, 1); fs();
    px(99, 20); px(100, 20); px(20, 19); px(20, 20); px(99, 99); px(99, 100);

    // 8x, partly off-screen: no wrap to the left edge
    cfg(0, 900, 1000, 3); fs();
    px(1023, 1000); px(5, 1000); px(1023, 1023); px(899, 1000);

    // back-to-back requests: second stalls and is dropped
    set_cfg(2, 0, 0, 0); cfg_valid = 1; tick();
    set_cfg(3, 0, 0, 0); tick();
    cfg_valid = 0;
    fs(); px(1, 1);

    // request coincident with frame_start waits one frame
    set_cfg(3, 5, 5, 0); cfg_valid = 1; frame_start = 1; tick();
    cfg_valid = 0; frame_start = 0;
    px(6, 6);
    fs(); px(6, 6); px(44, 44);

    // out-of-range image selector
    cfg(5, 0, 0, 0); fs();
    px(0, 0); px(10, 10); px(20, 20);

    // random placements and raster fragments
    for (int r = 0; r < 6; r++) begin
      int cx, cy, cs, w, t;
      cx = int'($urandom_range(0, 1000)); cy = int'($urandom_range(0, 1000));
      cs = int'($urandom_range(0, 3));
      cfg(int'($urandom_range(0, 4)), cx, cy, cs); fs();
      w = 40 << cs;
      for (int k = 0; k < 25; k++) begin
        pixel_valid = ($urandom_range(0, 3) != 0);
        t = cx + int'($urandom_range(0, w + 1)) - 1;
        pixel_x = 10'((t < 0) ? 0 : (t > 1023) ? 1023 : t);
        t = cy + int'($urandom_range(0, w + 1)) - 1;
        pixel_y = 10'((t < 0) ? 0 : (t > 1023) ? 1023 : t);
        tick();
      end
      pixel_valid = 0;
    end

    // reset mid-stream flushes the pipe and restores the default placement
    cfg(2, 100, 100, 2); fs();
    pixel_valid = 1; pixel_x = 10'd5; pixel_y = 10'd5;
    tick(); tick();
    rst = 1; tick();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      chk("flush_vld", {31'b0, rgb_valid}, 32'd0);
      tick();
    end
    pixel_valid = 0;
    fs(); px(5, 5);

    for (int i = 0; i < 6; i++) tick();
    chk("drain", q.size(), 32'd0);
    chk("idle_rgb", {20'b0, rgb}, 32'hFFF);
    chk("idle_inimg", {31'b0, in_image}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imemory_blit.md
Name: imemory_blit

Overview:
- Parametrised successor of the image memory block for the VGA pixel path.
- Holds NIMG images of IMG_W x IMG_H pixels in one ROM.
- Draws the selected image at a runtime position with runtime integer scaling (1x/2x/4x/8x) and a transparent colour key.
- Emits pipelined rgb aligned to a fixed latency. Configuration arrives via a valid/ready handshake and takes effect only at frame start (tear-free).

Parameters:
- DATA_W, 12, ROM word / rgb width.
- PIX_W, 10, pixel coordinate width.
- IMG_W, 40, image width in pixels.
- IMG_H, 40, image height in pixels.
- NIMG, 4, number of images stored back-to-back in ROM (image k at base k*IMG_W*IMG_H).
- ISEL_W, 2, image selector width (clog2(NIMG), min 1).
- ADDR_W, 13, ROM address width (clog2(NIMG*IMG_W*IMG_H)).
- FRAME_COLOR, 12'hFFF, colour outside image or when transparent.
- TRANSP_KEY, 12'hF0F, ROM value treated as transparent.
- HEXFILE, "none", ROM init file.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accepted when valid&ready
- cfg_isel  in  ISEL_W  image select
- cfg_x  in  PIX_W  image left column
- cfg_y  in  PIX_W  image top row
- cfg_scale  in  2  log2 scale factor
- frame_start  in  1  one-cycle pulse before first pixel of frame
- pixel_valid  in  1  pixel_x/pixel_y valid (active area)
- pixel_x  in  PIX_W  current column
- pixel_y  in  PIX_W  current row
- rgb  out  DATA_W  output colour
- rgb_valid  out  1  rgb corresponds to a valid input pixel
- in_image  out  1  pixel was inside image and opaque

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - Active and shadow config cleared: isel=0, x=0, y=0, scale=0, pending=0.
  - cfg_ready=1, rgb=0, rgb_valid=0, in_image=0.
  - All pipeline valid bits cleared. rst mid-frame flushes the pipeline: no rgb_valid for 3 cycles after release.
- Config handshake:
  - cfg_ready = !pending. On valid&ready, latch the shadow config and set pending.
  - On frame_start with pending, copy shadow to active, clear pending, and compute act_base = isel*IMG_W*IMG_H (registered).
  - cfg accepted in the same cycle as frame_start: frame_start uses the old shadow (none if not pending). The new config stays pending until the next frame_start.
  - cfg_valid while pending: stalled, ready=0.
- Invalid config: cfg_isel >= NIMG is accepted but the active block is disabled. Every pixel renders FRAME_COLOR with in_image=0.
- Geometry:
  - Extents are x_end = x + (IMG_W<<scale) - 1 and y_end likewise, computed in PIX_W+4 bits (no wrap).
  - Hit = pixel_valid & x <= pixel_x <= x_end & y <= pixel_y <= y_end (inclusive both edges).
  - Image partly off-screen: visible part drawn, no wrap.
- Address:
  - idx = (pixel_x - x) >> scale, idy = (pixel_y - y) >> scale.
  - addr = act_base + idy*IMG_W + idx. Constant multiply only; ADDR_W result, never out of range when hit.
- Pipeline (fixed latency 3, independent of hit):
  - S0 registers hit, idx, idy, valid.
  - S1 registers addr, drives ROM r_en = S1 hit, and registers hit/valid.
  - ROM returns data at S2. Output register: rgb = (hit & data != TRANSP_KEY) ? data : FRAME_COLOR.
  - in_image mirrors that condition. rgb_valid = S2 valid.
  - With pixel_valid=0: rgb=FRAME_COLOR, rgb_valid=0.
- Active config change at frame_start affects pixels presented from the cycle after frame_start. Pixels in flight finish with old config.

Decomposition:
- Package iob_im_blit_pkg:
  - constants: blit latency (3), scale width (2), default FRAME_COLOR/TRANSP_KEY
  - a config struct {isel, x, y, scale}
- Sub-module: existing iob_rom_sp (DATA_W, ADDR_W, HEXFILE), single instance.
- Optional sub-module imemory_blit_cfg holding the shadow/active registers and handshake.

Test Plan:
- Reset: rst held 2 cycles -> cfg_ready=1, rgb=0, rgb_valid=0. Default config, frame_start, pixel (0,0) -> after 3 cycles rgb=rom[0], rgb_valid=1.
- cfg {isel=1,x=20,y=20,scale=0} mid-frame -> pixel (25,22) still uses old config. After frame_start, pixel (25,22) -> rgb=rom[1600+2*40+5]=rom[1685].
- Edge: x=20, scale=1, pixel_x=99 (x_end) -> ROM pixel idx 39. pixel_x=100 -> FRAME_COLOR, in_image=0. pixel_y=19 -> FRAME_COLOR.
- Transparency: ROM word 12'hF0F at addr inside image -> rgb=12'hFFF, in_image=0. Neighbour 12'h123 -> rgb=12'h123, in_image=1.
- Handshake: two back-to-back cfg_valid with no frame_start -> first accepted, cfg_ready=0, second stalls. cfg_valid coincident with frame_start -> applied at the following frame_start. isel=5 (NIMG=4) -> all FRAME_COLOR.
- rst asserted mid-stream with pixel_valid=1 -> rgb_valid=0 for the next 3 cycles after release; active config back to default.
